data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//   Data-memory controller downstream of the single-cycle ARM core's data port.
//   Takes MemWrite/MemRead, the ALUResult address and WriteData, runs a
//   multi-cycle access to an external synchronous SRAM, and returns ReadData.
//   Stall freezes the PC and register writeback while an access is in flight.
// PARAMETERS
//   WAIT_CYCLES  2   extra SRAM wait states per access (0..15)
//   ADDR_W       10  SRAM word-address width; SRAM word = Addr[ADDR_W+1:2]
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-high
//   MemWrite   in   1       store request from the controller
//   MemRead    in   1       load request (driven from MemtoReg)
//   Addr       in   32      byte address (ALUResult)
//   WriteData  in   32      store data
//   ReadData   out  32      load data to the core
//   Stall      out  1       1 = core must hold PC and writeback this cycle
//   AlignErr   out  1       sticky; set on any access with Addr[1:0]!=0
//   sram_cs    out  1       SRAM chip select
//   sram_we    out  1       SRAM write enable
//   sram_addr  out  ADDR_W  SRAM word address
//   sram_wdata out  32      SRAM write data
//   sram_rdata in   32      SRAM read data, valid while sram_cs=1 and sram_we=0
// BEHAVIOUR
// - Reset (async): state=IDLE, cnt=0, rdata_q=0, AlignErr=0, sram_cs=0,
//   sram_we=0, sram_addr=0, sram_wdata=0, ReadData=0, Stall=0.
// - req = MemWrite | MemRead. If both are 1, the access is a write.
// - FSM IDLE -> ACCESS -> DONE -> IDLE:
//   IDLE:   req & aligned -> Stall=1 (combinational); at the edge, latch
//           addr/data/we into sram_*, set sram_cs=1 and cnt=WAIT_CYCLES, go to ACCESS.
//           No req -> Stall=0, ReadData=0.
//   ACCESS: Stall=1; sram_* held stable. If cnt!=0, decrement cnt.
//           If cnt==0, capture sram_rdata into rdata_q (reads only), clear
//           sram_cs/sram_we, go to DONE.
//   DONE:   Stall=0; ReadData=rdata_q for a read, 0 for a write. The core
//           advances at this edge. Always go to IDLE.
// - Latency: a request first seen in IDLE holds Stall for WAIT_CYCLES+2 cycles.
//   The following DONE cycle is unstalled and carries the result.
//   The SRAM is written exactly once per store.
// - A new request is accepted only in IDLE. Back-to-back accesses therefore
//   cost WAIT_CYCLES+3 cycles each.
// - Misaligned (Addr[1:0]!=0): no SRAM cycle, Stall=0, ReadData=0, AlignErr
//   set at the edge. AlignErr clears only on reset.
// - Address bits above ADDR_W+1 are ignored, so addresses alias modulo 4*2^ADDR_W.
// - Reset mid-access: FSM goes to IDLE and sram_cs/sram_we clear immediately.
//   Any in-flight store is dropped.
// - Inputs are sampled only in IDLE. Changes during ACCESS/DONE are ignored.
// CONFIGURATION
//   DMEM_MMIO_EN defined: addresses 0xFFFF_FF00..0xFFFF_FFFC are MMIO, served
//     in one cycle with no stall and no SRAM cycle.
//     - Adds ports led_out (out, 8) and sw_in (in, 8).
//     - 0xFFFF_FF00 write: led_out <= WriteData[7:0] at the edge (reset 0).
//     - 0xFFFF_FF00 read: ReadData = {24'b0, led_out}.
//     - 0xFFFF_FF04 read: ReadData = {24'b0, sw_in}, combinational.
//     - Other MMIO offsets: reads return 0, writes are ignored.
//   DMEM_MMIO_EN undefined: no MMIO ports. All aligned addresses go to the SRAM.
// TESTING
// 1. WAIT_CYCLES=2, store 0xDEADBEEF to 0x40 -> Stall high 4 cycles, one SRAM
//    write at word 0x10; then load 0x40 -> ReadData=0xDEADBEEF in the DONE cycle.
// 2. WAIT_CYCLES=0, load -> Stall high exactly 2 cycles, data in 3rd cycle.
// 3. Store to 0x41 -> no sram_cs, Stall=0, AlignErr=1 and stays 1 after a
//    later aligned access, until reset.
// 4. Assert reset during ACCESS of a store -> sram_cs=0 the same cycle,
//    state IDLE; a following load of that address returns its old value.
// 5. MemWrite=MemRead=1 to 0x80 with 0x12345678 -> treated as a write; a later
//    load of 0x80 returns 0x12345678.
// 6. DMEM_MMIO_EN: store 0xA5 to 0xFFFF_FF00 -> led_out=0xA5 next cycle, no
//    stall. sw_in=0x3C, load 0xFFFF_FF04 -> ReadData=0x0000003C.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Multi-cycle data-memory controller between the core data port
//            and an external synchronous SRAM; stalls the core while in flight.
//            Optional MMIO window enabled by defining DMEM_MMIO_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              AlignErr,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
`ifdef DMEM_MMIO_EN
    ,
    output logic [7:0]        led_out,
    input  logic [7:0]        sw_in
`endif
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_done   = 2'd2;
    localparam logic [3:0] c_wait   = 4'(WAIT_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_wr;

    logic        w_req;
    logic        w_aligned;
    logic        w_mmio;
    logic        w_start;
    logic [31:0] w_mmio_rdata;
    logic        w_unused_addr;

    assign w_req     = MemWrite | MemRead;
    assign w_aligned = (Addr[1:0] == 2'b00);

    // Upper address bits alias away: the SRAM only sees the word index.
    assign w_unused_addr = &{1'b0, Addr[31:ADDR_W+2]};

`ifdef DMEM_MMIO_EN
    assign w_mmio = (Addr[31:8] == 24'hFF_FFFF);
    always_comb begin
        w_mmio_rdata = 32'd0;
        if (Addr[7:0] == 8'h00)
            w_mmio_rdata = {24'd0, led_out};
        else if (Addr[7:0] == 8'h04)
            w_mmio_rdata = {24'd0, sw_in};
    end
`else
    assign w_mmio       = 1'b0;
    assign w_mmio_rdata = 32'd0;
`endif

    assign w_start = (r_state == c_idle) && w_req && w_aligned && !w_mmio;
    assign Stall   = w_start || (r_state == c_access);

    always_comb begin
        ReadData = 32'd0;
        if (r_state == c_done && !r_wr)
            ReadData = r_rdata;
        else if (r_state == c_idle && w_mmio && w_aligned && MemRead && !MemWrite)
            ReadData = w_mmio_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_idle;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'd0;
            r_wr       <= 1'b0;
            AlignErr   <= 1'b0;
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 32'd0;
`ifdef DMEM_MMIO_EN
            led_out    <= 8'd0;
`endif
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_req && !w_aligned) begin
                        AlignErr <= 1'b1;
                    end else if (w_req && w_mmio) begin
`ifdef DMEM_MMIO_EN
                        if (MemWrite && Addr[7:0] == 8'h00)
                            led_out <= WriteData[7:0];
`endif
                    end else if (w_start) begin
                        sram_cs    <= 1'b1;
                        sram_we    <= MemWrite;
                        sram_addr  <= Addr[ADDR_W+1:2];
                        sram_wdata <= WriteData;
                        r_wr       <= MemWrite;
                        r_cnt      <= c_wait;
                        r_state    <= c_access;
                    end
                end
                c_access: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!sram_we)
                            r_rdata <= sram_rdata;
                        sram_cs <= 1'b0;
                        sram_we <= 1'b0;
                        r_state <= c_done;
                    end
                end
                c_done:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Directed self-checking bench for data_mem_ctrl (WAIT_CYCLES=2 and 0).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // DUT with WAIT_CYCLES=2
    logic        mw, mr;
    logic [31:0] addr, wdata, rdata;
    logic        stall, alignerr, cs, we;
    logic [9:0]  saddr;
    logic [31:0] swdata, srdata;
    // DUT with WAIT_CYCLES=0
    logic        mw0, mr0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        stall0, alignerr0, cs0, we0;
    logic [9:0]  saddr0;
    logic [31:0] swdata0, srdata0;
`ifdef DMEM_MMIO_EN
    logic [7:0]  led, led0, sw;
`endif

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    logic [9:0]  last_waddr;
    logic [31:0] last_wdata;
    int          stalls;
    logic [31:0] rd;

    data_mem_ctrl #(.WAIT_CYCLES(2), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .MemWrite(mw), .MemRead(mr), .Addr(addr),
        .WriteData(wdata), .ReadData(rdata), .Stall(stall), .AlignErr(alignerr),
        .sram_cs(cs), .sram_we(we), .sram_addr(saddr), .sram_wdata(swdata),
        .sram_rdata(srdata)
`ifdef DMEM_MMIO_EN
        , .led_out(led), .sw_in(sw)
`endif
    );

    data_mem_ctrl #(.WAIT_CYCLES(0), .ADDR_W(10)) dut0 (
        .clk(clk), .reset(reset), .MemWrite(mw0), .MemRead(mr0), .Addr(addr0),
        .WriteData(wdata0), .ReadData(rdata0), .Stall(stall0), .AlignErr(alignerr0),
        .sram_cs(cs0), .sram_we(we0), .sram_addr(saddr0), .sram_wdata(swdata0),
        .sram_rdata(srdata0)
`ifdef DMEM_MMIO_EN
        , .led_out(led0), .sw_in(sw)
`endif
    );

    // SRAM models: preloaded with 0xC0DE0000|word, writes sampled mid-cycle.
    logic [31:0] mem  [0:1023];
    logic [31:0] mem0 [0:1023];
    assign srdata  = (cs  && !we)  ? mem[saddr]   : 32'hBAD0_BAD0;
    assign srdata0 = (cs0 && !we0) ? mem0[saddr0] : 32'hBAD0_BAD0;

    initial begin
        logic prev;
        prev = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
        forever begin
            @(negedge clk);
            if (cs && we) begin
                mem[saddr] = swdata;
                if (!prev) begin
                    wr_count++;
                    last_waddr = saddr;
                    last_wdata = swdata;
                end
            end
            prev = cs && we;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem0[i] = 32'hC0DE_0000 | i;
        forever begin
            @(negedge clk);
            if (cs0 && we0) mem0[saddr0] = swdata0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        mw = 0; mr = 0; addr = 0; wdata = 0;
        mw0 = 0; mr0 = 0; addr0 = 0; wdata0 = 0;
    endtask

    // Issue one access; returns stalled-cycle count and ReadData of the
    // first unstalled cycle. Called #1 after a rising edge.
    task automatic run(input bit sel, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d,
                       output int ns, output logic [31:0] rdo);
        if (sel) begin mw0 = w; mr0 = r; addr0 = a; wdata0 = d; end
        else     begin mw  = w; mr  = r; addr  = a; wdata  = d; end
        #1;
        ns = 0;
        while ((sel ? stall0 : stall) && ns < 40) begin
            ns++;
            @(posedge clk); #1;
            clear_inputs();
        end
        rdo = sel ? rdata0 : rdata;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
`ifdef DMEM_MMIO_EN
        sw = 8'h3C;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_alignerr", {31'd0, alignerr}, 32'd0);
        chk("rst_cs", {31'd0, cs}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_saddr", {22'd0, saddr}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Store then load, WAIT_CYCLES=2
        run(0, 1, 0, 32'h40, 32'hDEAD_BEEF, stalls, rd);
        chk("st40_stalls", stalls, 32'd4);
        chk("st40_rdata", rd, 32'd0);
        chk("st40_wrcount", wr_count, 32'd1);
        chk("st40_waddr", {22'd0, last_waddr}, 32'h10);
        chk("st40_wdata", last_wdata, 32'hDEAD_BEEF);
        run(0, 0, 1, 32'h40, 32'h0, stalls, rd);
        chk("ld40_stalls", stalls, 32'd4);
        chk("ld40_rdata", rd, 32'hDEAD_BEEF);
        run(0, 0, 1, 32'h1040, 32'h0, stalls, rd);
        chk("ld_alias_rdata", rd, 32'hDEAD_BEEF);
        run(0, 0, 1, 32'h44, 32'h0, stalls, rd);
        chk("ld44_rdata", rd, 32'hC0DE_0011);

        // WAIT_CYCLES=0 load
        run(1, 0, 1, 32'h8, 32'h0, stalls, rd);
        chk("w0_ld_stalls", stalls, 32'd2);
        chk("w0_ld_rdata", rd, 32'hC0DE_0002);

        // Misaligned store, sticky error
        run(0, 1, 0, 32'h41, 32'h1111_1111, stalls, rd);
        chk("mis_st_stalls", stalls, 32'd0);
        chk("mis_st_rdata", rd, 32'd0);
        chk("mis_st_alignerr", {31'd0, alignerr}, 32'd1);
        chk("mis_st_wrcount", wr_count, 32'd1);
        run(0, 0, 1, 32'h40, 32'h0, stalls, rd);
        chk("post_mis_ld_rdata", rd, 32'hDEAD_BEEF);
        chk("post_mis_alignerr", {31'd0, alignerr}, 32'd1);
        run(0, 0, 1, 32'h42, 32'h0, stalls, rd);
        chk("mis_ld_stalls", stalls, 32'd0);
        chk("mis_ld_rdata", rd, 32'd0);

        // Write+read simultaneously is a write
        run(0, 1, 1, 32'h80, 32'h1234_5678, stalls, rd);
        chk("wr_rd_stalls", stalls, 32'd4);
        chk("wr_rd_rdata", rd, 32'd0);
        chk("wr_rd_wrcount", wr_count, 32'd2);
        run(0, 0, 1, 32'h80, 32'h0, stalls, rd);
        chk("ld80_rdata", rd, 32'h1234_5678);

        // Reset in the middle of a store
        mw = 1; addr = 32'h100; wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        clear_inputs();
        chk("midrst_cs_before", {31'd0, cs}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_cs", {31'd0, cs}, 32'd0);
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_alignerr", {31'd0, alignerr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_wrcount", wr_count, 32'd2);
        run(0, 0, 1, 32'h100, 32'h0, stalls, rd);
        chk("midrst_ld_stalls", stalls, 32'd4);
        chk("midrst_ld_rdata", rd, 32'hC0DE_0040);

`ifdef DMEM_MMIO_EN
        run(0, 1, 0, 32'hFFFF_FF00, 32'h0000_00A5, stalls, rd);
        chk("mmio_st_stalls", stalls, 32'd0);
        chk("mmio_led", {24'd0, led}, 32'hA5);
        run(0, 0, 1, 32'hFFFF_FF04, 32'h0, stalls, rd);
        chk("mmio_sw_rdata", rd, 32'h3C);
        run(0, 0, 1, 32'hFFFF_FF00, 32'h0, stalls, rd);
        chk("mmio_led_rdata", rd, 32'hA5);
        run(0, 1, 0, 32'hFFFF_FF08, 32'h0000_0077, stalls, rd);
        chk("mmio_other_led", {24'd0, led}, 32'hA5);
        chk("mmio_wrcount", wr_count, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
